reg_wb_arbiter: RTL and testbench

//   Writer side of the GPR file: merges results from the ALU and the load unit

---
 rtl/reg_wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - ALU/load write-back merge onto the GPR file's single write port

module reg_wb_fifo #(
    parameter int N     = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_rd,
    input  logic [N-1:0]  push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_rd,
    output logic [N-1:0]  head_data,
    input  logic [AW-1:0] qaddr1,
    input  logic [AW-1:0] qaddr2,
    output logic          qhit1,
    output logic          qhit2
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [N-1:0]  data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                rd_mem[wr_ptr]   <= push_rd;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        qhit1 = 1'b0;
        qhit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr} < count) begin
                if (rd_mem[i] == qaddr1) qhit1 = 1'b1;
                if (rd_mem[i] == qaddr2) qhit2 = 1'b1;
            end
        end
    end
endmodule

module reg_wb_arbiter #(
    parameter int N          = 32,
    parameter int GPRS       = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = $clog2(GPRS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [N-1:0]  alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [N-1:0]  mem_data,
    output logic          we3,
    output logic [AW-1:0] addr3,
    output logic [N-1:0]  wd3,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic          byp1_hit,
    output logic [N-1:0]  byp1_data,
    output logic          byp2_hit,
    output logic [N-1:0]  byp2_data,
    output logic          pend1,
    output logic          pend2
);
    logic          alu_full, alu_empty, mem_full, mem_empty;
    logic          alu_push, mem_push;
    logic          grant_alu, grant_mem;
    logic [AW-1:0] alu_head_rd, mem_head_rd;
    logic [N-1:0]  alu_head_data, mem_head_data;
    logic          alu_q1, alu_q2, mem_q1, mem_q2;
    logic          pref_mem;

    assign alu_ready = !rst && !alu_full;
    assign mem_ready = !rst && !mem_full;

    // Writes to x0 finish the handshake but are never queued.
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_push = mem_valid && mem_ready && (mem_rd != '0);

    reg_wb_fifo #(.N(N), .AW(AW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .push_rd   (alu_rd),
        .push_data (alu_data),
        .pop       (grant_alu),
        .full      (alu_full),
        .empty     (alu_empty),
        .head_rd   (alu_head_rd),
        .head_data (alu_head_data),
        .qaddr1    (raddr1),
        .qaddr2    (raddr2),
        .qhit1     (alu_q1),
        .qhit2     (alu_q2)
    );

    reg_wb_fifo #(.N(N), .AW(AW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_push),
        .push_rd   (mem_rd),
        .push_data (mem_data),
        .pop       (grant_mem),
        .full      (mem_full),
        .empty     (mem_empty),
        .head_rd   (mem_head_rd),
        .head_data (mem_head_data),
        .qaddr1    (raddr1),
        .qaddr2    (raddr2),
        .qhit1     (mem_q1),
        .qhit2     (mem_q2)
    );

    assign grant_alu = !alu_empty && (mem_empty || !pref_mem);
    assign grant_mem = !mem_empty && !grant_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            we3      <= 1'b0;
            addr3    <= '0;
            wd3      <= '0;
            pref_mem <= 1'b0;
        end else if (grant_alu) begin
            we3      <= 1'b1;
            addr3    <= alu_head_rd;
            wd3      <= alu_head_data;
            pref_mem <= 1'b1;
        end else if (grant_mem) begin
            we3      <= 1'b1;
            addr3    <= mem_head_rd;
            wd3      <= mem_head_data;
            pref_mem <= 1'b0;
        end else begin
            we3      <= 1'b0;
        end
    end

    assign byp1_hit  = we3 && (raddr1 != '0) && (raddr1 == addr3);
    assign byp2_hit  = we3 && (raddr2 != '0) && (raddr2 == addr3);
    assign byp1_data = wd3;
    assign byp2_data = wd3;

    // Queued entries only; the write on the port is covered by bypass.
    assign pend1 = (raddr1 != '0) && (alu_q1 || mem_q1);
    assign pend2 = (raddr2 != '0) && (alu_q2 || mem_q2);
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - scoreboard bench for reg_wb_arbiter

module tb_reg_wb_arbiter;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0, raddr1 = '0, raddr2 = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, we3;
    logic [4:0]  addr3;
    logic [31:0] wd3, byp1_data, byp2_data;
    logic        byp1_hit, byp2_hit, pend1, pend2;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.N(32), .GPRS(32), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3), .addr3(addr3), .wd3(wd3),
        .raddr1(raddr1), .raddr2(raddr2),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data),
        .pend1(pend1), .pend2(pend2)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state (written only by the model process).
    ent_t qa[$];
    ent_t qm[$];
    ent_t sb[$];
    bit   pref_mem = 1'b0;
    int   rst_gen = 0;

    // Monitor state (written only by the monitor process).
    int          tests = 0, fails = 0;
    int          rd_idx = 0, seen_gen = 0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_wd = '0;
    bit          stim_done = 1'b0;

    // Model: one grant per edge from the queue heads, round robin on ties,
    // then accept the pushes offered under the pre-edge readiness.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qm.delete();
            pref_mem = 1'b0;
            rst_gen++;
        end else begin
            bit ra, rm;
            ra = qa.size() < D;
            rm = qm.size() < D;
            if (qa.size() > 0 && (qm.size() == 0 || !pref_mem)) begin
                sb.push_back(qa.pop_front());
                pref_mem = 1'b1;
            end else if (qm.size() > 0) begin
                sb.push_back(qm.pop_front());
                pref_mem = 1'b0;
            end
            if (alu_valid && ra && alu_rd != 0) qa.push_back('{alu_rd, alu_data});
            if (mem_valid && rm && mem_rd != 0) qm.push_back('{mem_rd, mem_data});
        end
    end

    function automatic bit queued(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (qa[i]) if (qa[i].rd == a) return 1'b1;
        foreach (qm[i]) if (qm[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle, compare the port against the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (rst_gen != 0) begin
            bit exp_we;
            if (rst_gen != seen_gen) begin
                seen_gen = rst_gen;
                e_addr = '0;
                e_wd = '0;
            end
            exp_we = sb.size() > rd_idx;
            if (exp_we) begin
                e_addr = sb[rd_idx].rd;
                e_wd   = sb[rd_idx].data;
                rd_idx++;
            end
            chk("we3", 32'(we3), 32'(exp_we));
            chk("addr3", 32'(addr3), 32'(e_addr));
            chk("wd3", wd3, e_wd);
            chk("byp1_hit", 32'(byp1_hit), 32'(exp_we && raddr1 != 0 && raddr1 == e_addr));
            chk("byp2_hit", 32'(byp2_hit), 32'(exp_we && raddr2 != 0 && raddr2 == e_addr));
            chk("byp1_data", byp1_data, e_wd);
            chk("byp2_data", byp2_data, e_wd);
            chk("pend1", 32'(pend1), 32'(queued(raddr1)));
            chk("pend2", 32'(pend2), 32'(queued(raddr2)));
            chk("alu_ready", 32'(alu_ready), 32'(!rst && qa.size() < D));
            chk("mem_ready", 32'(mem_ready), 32'(!rst && qm.size() < D));
        end
        if (stim_done) begin
            chk("drained", 32'(sb.size() - rd_idx + qa.size() + qm.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic cyc(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst = r;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        raddr1 = r1; raddr2 = r2;
    endtask

    initial begin
        // Reset with both producers offering.
        cyc(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        cyc(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        // Single ALU write, then observe bypass on raddr1.
        cyc(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 5'd5, 5'd0);
        repeat (3) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        // Contention: ALU rd 1..4 against MEM rd 11..14.
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 5'(1 + i), 32'hA000 + i, 1, 5'(11 + i), 32'hB000 + i, 5'(1 + i), 5'(11 + i));
        repeat (6) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd2, 5'd12);
        // Backpressure: both saturating, each FIFO drains at half rate.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 5'(20 + i), $urandom, 1, 5'(6 + i), $urandom, 5'(20 + i), 5'(6 + i));
        repeat (6) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        // x0 drop.
        cyc(0, 1, 5'd0, 32'd7, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        // Pending then bypass on raddr2.
        cyc(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 5'd0, 5'd9);
        repeat (3) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd9);
        // Reset with entries queued.
        cyc(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd3, 5'd4);
        cyc(0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 5'd7, 5'd8);
        cyc(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd8);
        repeat (4) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, 5'd8);
        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 63) == 0),
                $urandom_range(0, 1), 5'($urandom), $urandom,
                $urandom_range(0, 1), 5'($urandom), $urandom,
                5'($urandom), 5'($urandom));
        repeat (10) cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        stim_done = 1'b1;
    end
endmodule
